shift_feed_fifo: RTL and testbench
==================================

# shift_feed_fifo

Synchronous FIFO that sits directly upstream of `shift_reg` and feeds it. It accepts words from a valid/ready producer, buffers up to `Depth` entries, and drains one word per cycle into the shift register as a registered `we_o`/`data_o` pair whenever the downstream drain enable is high. It decouples bursty producers from the shift register's write timing.

## Interface
- `Width`, 8, data word width in bits; matches `shift_reg` `Width`.
- `Depth`, 4, number of buffered entries; power of two, ≥ 2.
- `clk_i` input 1: single clock; all state updates on the rising edge.
- `rst_ni` input 1: reset, synchronous, active-low.
- `valid_i` input 1: producer offers `data_i` this cycle.
- `ready_o` output 1: FIFO accepts a word this cycle; `ready_o = rst_ni && !full_o`.
- `data_i` input `Width`: producer data.
- `en_i` input 1: drain enable from downstream control.
- `we_o` output 1: registered write strobe to `shift_reg` `we_i`.
- `data_o` output `Width`: registered data to `shift_reg` `data_i`.
- `count_o` output `$clog2(Depth)+1`: current number of stored entries.
- `full_o` output 1: `count_o == Depth`.
- `empty_o` output 1: `count_o == 0`.

## Operation
- Push: a word is pushed on an edge where `valid_i && ready_o`. It is written at `wr_ptr`, and `wr_ptr` increments modulo `Depth`.
- Pop: a word is popped on an edge where `en_i && !empty_o`. On that edge:
  - `data_o <= mem[rd_ptr]` and `we_o <= 1`.
  - `rd_ptr` increments modulo `Depth`.
- No pop on an edge: `we_o <= 0` and `data_o` holds its last value.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
  - neither: unchanged.
- Full: `ready_o = 0`, so no push can occur. A pop on that edge does not enable a same-edge push, because `ready_o` does not look ahead.
- Empty: no pop, and `we_o` is 0 on the next cycle, unless the bypass below is compiled in.
- Pointer wrap: pointers are `$clog2(Depth)` bits and wrap naturally. `full_o` and `empty_o` are derived from `count_o`, not from pointer comparison.
- Reset (`rst_ni` low at an edge):
  - `wr_ptr`, `rd_ptr`, `count_o` are cleared to 0.
  - `we_o` and `data_o` are cleared to 0.
  - Memory contents are don't-care.
  - While `rst_ni` is low, `ready_o = 0`, and any push or pop on that edge is discarded.
  - A reset mid-burst drops all buffered entries.

## Timing
- Reset values: `we_o = 0`, `data_o = 0`, `count_o = 0`, `empty_o = 1`, `full_o = 0`. `ready_o = 1` once `rst_ni` is high.
- `ready_o`, `full_o`, `empty_o` are combinational from registered `count_o` (plus `rst_ni` for `ready_o`). They have no combinational path from `valid_i` or `en_i`.
- Latency without bypass:
  - A word pushed at edge N can be popped at edge N+1 at the earliest.
  - `we_o`/`data_o` are valid in cycle N+1 → N+2.
  - `shift_reg` captures the word at edge N+2.
- Throughput: one push and one pop per cycle in steady state.
- `we_o` stays high for exactly one cycle per popped word. Back-to-back pops give a continuous `we_o` with a new `data_o` every cycle.

## Configuration
- `SHIFT_FEED_FIFO_BYPASS_EN` defined:
  - Condition: an edge where `empty_o && en_i && valid_i && ready_o`.
  - On that edge, `data_i` goes directly to `data_o`, with `we_o <= 1`.
  - Nothing is written to memory; `count_o` and both pointers are unchanged.
  - Push-to-`we_o` latency is 1 edge.
- `SHIFT_FEED_FIFO_BYPASS_EN` undefined: the same case performs a normal push, and `we_o <= 0` on that edge.
- All other behaviour is identical in both builds.

## Test plan
- Reset: hold `rst_ni = 0` for 2 edges with `valid_i = 1`, `en_i = 1` → `we_o = 0`, `data_o = 0`, `count_o = 0`, `ready_o = 0`; after release, `ready_o = 1`.
- Fill and drain (`Depth = 4`):
  - Stimulus: `en_i = 0`; push `f0`, `a0`, `80`, `60` on 4 edges.
  - Expected after fill: `full_o = 1`, `ready_o = 0`; a 5th `valid_i` with `49` is not accepted.
  - Then raise `en_i` → `we_o` is high for 4 cycles, with `data_o = f0, a0, 80, 60` in order, then `we_o = 0`, `empty_o = 1`.
- Simultaneous push/pop with `count_o = 2`: `valid_i = 1`, `en_i = 1` for 3 edges → `count_o` stays 2 and `data_o` follows FIFO order.
- Wrap-around: push/pop 10 words `00..09` through `Depth = 4` → output order is exactly `00..09`, with no loss or duplication.
- Reset mid-burst: with 3 entries stored, assert `rst_ni = 0` for one edge → `count_o = 0`, `we_o = 0`; the next pushed `c3` is the first word out.
- Bypass, run in both builds: empty FIFO, `en_i = 1`, push `15` at edge N.
  - With `SHIFT_FEED_FIFO_BYPASS_EN`: `we_o = 1`, `data_o = 15` after edge N, and `count_o = 0`.
  - Without it: `we_o = 1`, `data_o = 15` after edge N+1.

Source files
------------

// File: rtl/shift_feed_fifo.sv
// Buffers valid/ready producer words and drains one per cycle into shift_reg as a registered we_o/data_o pair.
// Optional build macro SHIFT_FEED_FIFO_BYPASS_EN: empty-FIFO words go straight to data_o in one edge.
module shift_feed_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [Width-1:0]         data_i,
  input  logic                     en_i,
  output logic                     we_o,
  output logic [Width-1:0]         data_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;

  logic push;
  logic pop;
  logic bypass;
  logic push_mem;

  // Handshake: a word transfers on an edge where valid_i && ready_o; ready_o
  // depends only on registered count and rst_ni, never on valid_i or en_i.
  assign full_o  = (count_o == CntW'(Depth));
  assign empty_o = (count_o == '0);
  assign ready_o = rst_ni && !full_o;

  assign push = valid_i && ready_o;
  assign pop  = en_i && !empty_o;

`ifdef SHIFT_FEED_FIFO_BYPASS_EN
  assign bypass = empty_o && en_i && push;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word never touches memory, pointers or count.
  assign push_mem = push && !bypass;

  always_ff @(posedge clk_i) begin
    if (push_mem) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (push_mem) begin
        wr_ptr <= wr_ptr + PtrW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      case ({push_mem, pop})
        2'b10:   count_o <= count_o + CntW'(1);
        2'b01:   count_o <= count_o - CntW'(1);
        default: count_o <= count_o;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      we_o   <= 1'b0;
      data_o <= '0;
    end else begin
      we_o <= pop || bypass;
      if (bypass) begin
        data_o <= data_i;
      end else if (pop) begin
        data_o <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_shift_feed_fifo.sv
// Randomized and directed bench for shift_feed_fifo against a queue-based reference model.
// Honours SHIFT_FEED_FIFO_BYPASS_EN so the same bench checks either build.
module tb_shift_feed_fifo;

  localparam int W = 8;
  localparam int D = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk;
  logic          rst_n;
  logic          valid;
  logic          ready;
  logic [W-1:0]  data_in;
  logic          en;
  logic          we;
  logic [W-1:0]  data_out;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  shift_feed_fifo #(.Width(W), .Depth(D)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .valid_i (valid),
    .ready_o (ready),
    .data_i  (data_in),
    .en_i    (en),
    .we_o    (we),
    .data_o  (data_out),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic         exp_we;
  logic [W-1:0] exp_data;
  int           n_compared;
  int           n_mismatched;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model across the edge, then compare all outputs.
  task automatic step(input logic r, input logic v, input logic [W-1:0] d, input logic e);
    logic acc;
    logic take;
    logic byp;
    rst_n   = r;
    valid   = v;
    data_in = d;
    en      = e;
    acc  = r && v && (exp_q.size() < D);
    take = r && e && (exp_q.size() > 0);
`ifdef SHIFT_FEED_FIFO_BYPASS_EN
    byp = acc && e && (exp_q.size() == 0);
`else
    byp = 1'b0;
`endif
    @(posedge clk);
    if (!r) begin
      exp_q.delete();
      exp_we   = 1'b0;
      exp_data = '0;
    end else begin
      exp_we = take || byp;
      if (byp) exp_data = d;
      else if (take) exp_data = exp_q.pop_front();
      if (acc && !byp) exp_q.push_back(d);
    end
    #1;
    check("we", we, exp_we);
    check("data", data_out, exp_data);
    check("count", count, exp_q.size());
    check("full", full, exp_q.size() == D);
    check("empty", empty, exp_q.size() == 0);
    check("ready", ready, r && (exp_q.size() < D));
  endtask

  task automatic drain();
    for (int i = 0; i < D + 2; i++) step(1'b1, 1'b0, '0, 1'b1);
  endtask

  initial begin
    logic [W-1:0] fill_words [4];
    n_compared   = 0;
    n_mismatched = 0;
    exp_we   = 1'b0;
    exp_data = '0;
    fill_words[0] = 8'hf0;
    fill_words[1] = 8'ha0;
    fill_words[2] = 8'h80;
    fill_words[3] = 8'h60;

    // reset with valid and enable asserted
    step(1'b0, 1'b1, 8'h11, 1'b1);
    step(1'b0, 1'b1, 8'h22, 1'b1);
    check("ready_in_reset", ready, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);

    // fill, refused fifth word, drain in order
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, fill_words[i], 1'b0);
    step(1'b1, 1'b1, 8'h49, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, '0, 1'b1);
      check("drain_order", data_out, fill_words[i]);
    end
    step(1'b1, 1'b0, '0, 1'b1);

    // simultaneous push and pop at count 2
    step(1'b1, 1'b1, 8'h31, 1'b0);
    step(1'b1, 1'b1, 8'h32, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, W'(8'h40 + i), 1'b1);
      check("steady_count", count, 2);
    end
    drain();

    // wrap-around with words 00..09
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, W'(i), i > 0);
    drain();

    // reset mid-burst
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, W'(8'h70 + i), 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 8'hc3, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    check("first_after_reset", data_out, 8'hc3);
    drain();

    // push into empty FIFO with drain enabled
    step(1'b1, 1'b1, 8'h15, 1'b1);
`ifdef SHIFT_FEED_FIFO_BYPASS_EN
    check("bypass_we", we, 1'b1);
    check("bypass_data", data_out, 8'h15);
`else
    check("nobypass_we", we, 1'b0);
`endif
    step(1'b1, 1'b0, '0, 1'b1);
`ifndef SHIFT_FEED_FIFO_BYPASS_EN
    check("nobypass_data", data_out, 8'h15);
`endif
    step(1'b1, 1'b0, '0, 1'b0);

    // random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 49) != 0, $urandom_range(0, 2) != 0,
           W'($urandom), $urandom_range(0, 2) != 0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
